// File: rtl/rsa_pkg.sv
// Shared constants, operand-select encodings and sequencer states for the
// RSA modular-exponentiation datapath.
package rsa_pkg;

  localparam int unsigned DATA_LENGTH = 1024;
  localparam int unsigned DATA_WIDTH  = $clog2(DATA_LENGTH);

  localparam logic [1:0] SEL_A_AREG = 2'd0;
  localparam logic [1:0] SEL_A_M    = 2'd1;
  localparam logic [1:0] SEL_A_MBAR = 2'd2;

  localparam logic [1:0] SEL_B_AREG = 2'd0;
  localparam logic [1:0] SEL_B_MBAR = 2'd1;
  localparam logic [1:0] SEL_B_T    = 2'd2;
  localparam logic [1:0] SEL_B_ONE  = 2'd3;

  localparam logic DST_AREG = 1'b0;
  localparam logic DST_MBAR = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    TOMONT,
    INITA,
    SCAN,
    SQR,
    MUL,
    NEXT,
    FROMMONT
  } state_t;

endpackage

// File: rtl/rsa_mm_issue.sv
// Montgomery-multiplier handshake helper: turns an op request into a single
// mm_start pulse, holds the selects and reports completion.
module rsa_mm_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_op_req,
  input  logic [1:0] i_a_sel,
  input  logic [1:0] i_b_sel,
  input  logic       i_dst_sel,
  input  logic       i_mm_done,
  output logic       o_mm_start,
  output logic [1:0] o_a_sel,
  output logic [1:0] o_b_sel,
  output logic       o_dst_sel,
  output logic       o_pending,
  output logic       o_op_done
);

  logic       r_mm_start;
  logic       r_pending;
  logic [1:0] r_a_sel;
  logic [1:0] r_b_sel;
  logic       r_dst_sel;

  // r_pending rises together with mm_start, so a done in the start cycle
  // still counts as completion of this op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm_start <= 1'b0;
      r_pending  <= 1'b0;
      r_a_sel    <= '0;
      r_b_sel    <= '0;
      r_dst_sel  <= 1'b0;
    end else begin
      r_mm_start <= 1'b0;
      if (i_op_req && !r_pending) begin
        r_mm_start <= 1'b1;
        r_pending  <= 1'b1;
        r_a_sel    <= i_a_sel;
        r_b_sel    <= i_b_sel;
        r_dst_sel  <= i_dst_sel;
      end else if (r_pending && i_mm_done) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign o_mm_start = r_mm_start;
  assign o_a_sel    = r_a_sel;
  assign o_b_sel    = r_b_sel;
  assign o_dst_sel  = r_dst_sel;
  assign o_pending  = r_pending;
  assign o_op_done  = r_pending & i_mm_done;

endmodule

// File: rtl/rsa_modexp_sched.sv
// Left-to-right binary Montgomery exponentiation sequencer: launches the
// precompute, then issues TOMONT / SQR / MUL / FROMMONT ops to the multiplier.
module rsa_modexp_sched #(
  parameter int unsigned DATA_LENGTH = rsa_pkg::DATA_LENGTH,
  parameter int unsigned IDX_W       = 10,
  parameter int unsigned OPC_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] exp,
  input  logic                   reuse_pre,
  input  logic                   n_change,
  output logic                   pre_start,
  input  logic                   pre_done,
  output logic                   mm_start,
  input  logic                   mm_done,
  output logic [1:0]             mm_a_sel,
  output logic [1:0]             mm_b_sel,
  output logic                   mm_dst_sel,
  output logic                   load_a_r,
  output logic                   busy,
  output logic                   done,
  output logic [OPC_W-1:0]       op_count
);
  import rsa_pkg::*;

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_LENGTH-1:0] r_exp;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pre_valid;
  logic                   r_pre_start;
  logic                   r_load_a;
  logic                   r_done;
  logic [OPC_W-1:0]       r_opc;

  logic                   w_accept;
  logic                   w_bit;
  logic                   w_idx_zero;
  logic                   w_req;
  logic [1:0]             w_a_sel;
  logic [1:0]             w_b_sel;
  logic                   w_dst_sel;
  logic                   w_pending;
  logic                   w_op_done;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_bit      = r_exp[r_idx];
  assign w_idx_zero = (r_idx == '0);

  rsa_mm_issue u_issue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_op_req  (w_req),
    .i_a_sel   (w_a_sel),
    .i_b_sel   (w_b_sel),
    .i_dst_sel (w_dst_sel),
    .i_mm_done (mm_done),
    .o_mm_start(mm_start),
    .o_a_sel   (mm_a_sel),
    .o_b_sel   (mm_b_sel),
    .o_dst_sel (mm_dst_sel),
    .o_pending (w_pending),
    .o_op_done (w_op_done)
  );

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_a_sel   = SEL_A_AREG;
    w_b_sel   = SEL_B_AREG;
    w_dst_sel = DST_AREG;
    case (r_state)
      IDLE: begin
        if (start) w_next = (reuse_pre && r_pre_valid) ? TOMONT : PRE;
      end
      PRE: begin
        if (pre_done) w_next = TOMONT;
      end
      TOMONT: begin
        w_req     = !w_pending;
        w_a_sel   = SEL_A_M;
        w_b_sel   = SEL_B_T;
        w_dst_sel = DST_MBAR;
        if (w_op_done) w_next = INITA;
      end
      INITA: w_next = SCAN;
      SCAN: begin
        if (w_bit)           w_next = SQR;
        else if (w_idx_zero) w_next = FROMMONT;
      end
      SQR: begin
        w_req = !w_pending;
        if (w_op_done) w_next = w_bit ? MUL : NEXT;
      end
      MUL: begin
        w_req   = !w_pending;
        w_b_sel = SEL_B_MBAR;
        if (w_op_done) w_next = NEXT;
      end
      NEXT: w_next = w_idx_zero ? FROMMONT : SQR;
      FROMMONT: begin
        w_req   = !w_pending;
        w_b_sel = SEL_B_ONE;
        if (w_op_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_exp       <= '0;
      r_idx       <= '0;
      r_pre_valid <= 1'b0;
      r_pre_start <= 1'b0;
      r_load_a    <= 1'b0;
      r_done      <= 1'b0;
      r_opc       <= '0;
    end else begin
      r_state     <= w_next;
      r_pre_start <= w_accept && (w_next == PRE);
      r_load_a    <= (r_state == TOMONT) && w_op_done;
      r_done      <= (r_state == FROMMONT) && w_op_done;

      if (w_accept) r_exp <= exp;

      if (r_state == INITA)
        r_idx <= IDX_W'(DATA_LENGTH - 1);
      else if (((r_state == SCAN) && !w_bit && !w_idx_zero) ||
               ((r_state == NEXT) && !w_idx_zero))
        r_idx <= r_idx - IDX_W'(1);

      // A modulus reload beats a same-cycle precompute completion.
      if (n_change)
        r_pre_valid <= 1'b0;
      else if ((r_state == PRE) && pre_done)
        r_pre_valid <= 1'b1;

      if (w_accept)
        r_opc <= '0;
      else if (mm_start && (r_opc != '1))
        r_opc <= r_opc + OPC_W'(1);
    end
  end

  assign pre_start = r_pre_start;
  assign load_a_r  = r_load_a;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_opc;

endmodule
